instr_feeder: RTL

INSTR_FEEDER -- requirements
Module: instr_feeder

---
 rtl/instr_feeder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/instr_feeder.sv
// Instruction feeder: holds a small program in local memory and issues it word by word
// to a downstream processor, waiting for its Done handshake between instructions.
module instr_feeder #(
    parameter int N  = 9,
    parameter int AW = 5
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stop,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [N-1:0]  LoadData,
    input  logic [AW-1:0] EndAddr,
    input  logic          Done,
    output logic [N-1:0]  DIN,
    output logic          Run,
    output logic [AW-1:0] PC,
    output logic          Busy,
    output logic [7:0]    InstrCount,
    output logic          LoadErr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_IMM,
        S_WAIT
    } state_t;

    localparam logic [2:0] OP_MVI = 3'b001;

    logic [N-1:0]  mem [2**AW];

    state_t        state_q, state_d;
    logic [N-1:0]  din_q, din_d;
    logic          run_q, run_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          load_err_q, load_err_d;
    logic          stop_pend_q, stop_pend_d;
    logic          busy;

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        run_d       = 1'b0;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        load_err_d  = load_err_q | (LoadEn & busy);
        stop_pend_d = stop_pend_q | (Stop & busy);

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d     = S_FETCH;
                    pc_d        = '0;
                    cnt_d       = '0;
                    load_err_d  = 1'b0;
                    // A Stop arriving together with Start limits the run to one instruction.
                    stop_pend_d = Stop;
                end
            end
            S_FETCH: begin
                din_d   = mem[pc_q];
                pc_d    = pc_q + 1'b1;
                run_d   = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (din_q[N-1 -: 3] == OP_MVI) begin
                    din_d   = mem[pc_q];
                    pc_d    = pc_q + 1'b1;
                    state_d = S_IMM;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_IMM: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (Done) begin
                    cnt_d = (cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
                    if (stop_pend_q || Stop || (pc_q == EndAddr)) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            din_q       <= '0;
            run_q       <= 1'b0;
            pc_q        <= '0;
            cnt_q       <= '0;
            load_err_q  <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            run_q       <= run_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            load_err_q  <= load_err_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Program memory survives reset so a halted or interrupted program can be rerun.
    always_ff @(posedge Clock) begin
        if (LoadEn && !busy) begin
            mem[LoadAddr] <= LoadData;
        end
    end

    assign DIN        = din_q;
    assign Run        = run_q;
    assign PC         = pc_q;
    assign Busy       = busy;
    assign InstrCount = cnt_q;
    assign LoadErr    = load_err_q;

endmodule
